wishbone_bus_arbiter: RTL and testbench
=======================================

Name: wishbone_bus_arbiter

Overview:
- Shares one Wishbone B3 classic slave port (the SoC interconnect/memory side) between N CPU bus masters.
- Default N=2: master 0 is the data-side wishbone_bus_if, master 1 is the instruction-side wishbone_bus_if.
- Round-robin arbitration with a bus lock held for the whole master cycle (cyc).
- Timeout watchdog aborts a hung slave with an error strobe, so the pipeline stall always resolves.

Parameters:
N_MASTER, 2, number of requesting masters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT_CYC, 255, cycles of stb without ack/err before abort (1..65535)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; one clock; reset is asynchronous and active-high
i_m_cyc  in  N_MASTER  per-master cycle request
i_m_stb  in  N_MASTER  per-master strobe
i_m_we  in  N_MASTER  per-master write enable
i_m_sel  in  4*N_MASTER  byte selects, master k at [4k+3:4k]
i_m_addr  in  ADDR_W*N_MASTER  addresses, packed by master index
i_m_data  in  DATA_W*N_MASTER  write data, packed by master index
o_m_data  out  DATA_W  read data, broadcast to all masters
o_m_ack  out  N_MASTER  ack, granted master only
o_m_err  out  N_MASTER  error/timeout strobe, granted master only
o_s_cyc, o_s_stb, o_s_we  out  1  slave control
o_s_sel  out  4  slave byte select
o_s_addr  out  ADDR_W  slave address
o_s_data  out  DATA_W  slave write data
i_s_data  in  DATA_W  slave read data
i_s_ack  in  1  slave ack
i_s_err  in  1  slave error
o_grant  out  N_MASTER  one-hot registered grant (debug/perf counters)

Behaviour:
- Reset (async, immediate):
  - state=S_IDLE; grant=0; last-grant pointer=N_MASTER-1, so master 0 wins first.
  - Timeout counter=0.
  - All o_s_*, o_m_ack, o_m_err, o_m_data and o_grant are 0.
  - Reset mid-transfer drops o_s_cyc/o_s_stb in the same instant; no ack/err is delivered.
- States: S_IDLE, S_BUSY, S_ABORT.
- S_IDLE:
  - Request vector req = i_m_cyc & i_m_stb.
  - If req!=0, pick the first set bit searching from pointer+1 with wrap-around.
  - Register a one-hot grant and go to S_BUSY.
  - Arbitration latency is 1 cycle: a request seen at edge t appears on o_s_* after edge t+1.
  - With no request, stay in S_IDLE with outputs 0.
- S_BUSY:
  - o_s_cyc=1 while granted i_m_cyc=1.
  - o_s_stb, we, sel, addr and data are muxed combinationally from the granted master.
  - o_m_ack[g] = i_s_ack & i_m_stb[g]; o_m_err[g] = i_s_err & i_m_stb[g]; all other masters see 0.
  - o_m_data = i_s_data in S_BUSY, 0 otherwise.
  - The lock is held while i_m_cyc[g]=1, so back-to-back strobes under one cyc are not re-arbitrated.
  - When i_m_cyc[g]=0: pointer<=g, grant<=0, go to S_IDLE. Other requesters wait at least 1 idle cycle.
- Timeout:
  - Counter increments each S_BUSY cycle with o_s_stb=1 and no i_s_ack/i_s_err.
  - Counter clears on ack, err, or a stb-low cycle.
  - When counter==TIMEOUT_CYC-1 and no ack that cycle: pulse o_m_err[g] for 1 cycle and go to S_ABORT.
  - An ack in the same cycle as expiry wins: it is forwarded, the counter clears, and no err is raised.
- S_ABORT:
  - o_s_cyc=o_s_stb=0 for exactly 1 cycle.
  - pointer<=g, then S_IDLE.
  - A late i_s_ack arriving in S_ABORT/S_IDLE is ignored and not forwarded.
- Slave outputs are 0 whenever the state is not S_BUSY.
- Masters not granted see ack=err=0 regardless of slave activity.

Decomposition:
- Package wishbone_arb_pkg holds:
  - state enum arb_state_t {S_IDLE, S_BUSY, S_ABORT};
  - SEL_W=4;
  - function onehot2idx.
- WRITE_DISABLE stays in defines.svh.
- One sub-module: wb_rr_picker. It is combinational: req, pointer in; one-hot grant and valid out; parameter N_MASTER.

Test Plan:
- Single read:
  - Stimulus: master 0 cyc/stb, addr 0x0000_0100, we=0; slave acks 2 cycles after o_s_stb with data 0xDEADBEEF.
  - Required: o_s_stb rises 1 cycle after request; o_m_ack=2'b01 for 1 cycle with o_m_data=0xDEADBEEF; o_m_ack[1] stays 0.
- Simultaneous requests from reset:
  - Stimulus: both masters request on the same edge.
  - Required: master 0 granted first; after it drops cyc, 1 idle cycle, then master 1 granted; a third concurrent round grants master 0 again.
- Lock:
  - Stimulus: master 1 holds cyc across 3 strobes (writes 0x11, 0x22, 0x33, sel=4'hF) while master 0 requests continuously.
  - Required: all 3 writes reach the slave in order; master 0 is granted only after master 1 drops cyc.
- Timeout:
  - Stimulus: TIMEOUT_CYC=8, slave never acks.
  - Required: o_m_err[g] pulses exactly 8 cycles after o_s_stb rose; o_s_cyc is low for 1 cycle; a late ack is not forwarded.
- Expiry tie:
  - Stimulus: slave acks in the cycle the counter expires.
  - Required: ack forwarded and no err.
- Reset mid-transfer:
  - Stimulus: assert i_rst during S_BUSY.
  - Required: all outputs are 0 asynchronously; after release, master 0 has priority again.

Source files
------------

// File: rtl/wishbone_arb_pkg.sv
// Shared types and helpers for the Wishbone bus arbiter.
//   arb_state_t : arbiter FSM encoding
//   SEL_W       : byte-select width of the Wishbone port
//   onehot2idx  : encodes a one-hot grant (up to 8 masters) into an index
package wishbone_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_ABORT
    } arb_state_t;

    localparam int unsigned SEL_W = 4;

    // OR-based encoder; the result is only meaningful for a one-hot
    // (or all-zero) input.
    function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx[2] = |oh[7:4];
        idx[1] = oh[2] | oh[3] | oh[6] | oh[7];
        idx[0] = oh[1] | oh[3] | oh[5] | oh[7];
        return idx;
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker.
//   req_i   : request vector, one bit per master
//   ptr_i   : index of the master granted last
//   grant_o : one-hot winner, first set request after ptr_i with wrap-around
//   valid_o : at least one request is present
module wb_rr_picker #(
    parameter int unsigned N_MASTER = 2,
    parameter int unsigned PTR_W    = $clog2(N_MASTER)
) (
    input  logic [N_MASTER-1:0] req_i,
    input  logic [PTR_W-1:0]    ptr_i,
    output logic [N_MASTER-1:0] grant_o,
    output logic                valid_o
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        // Offsets 1..N visit every master once, starting just after ptr_i
        // and ending on ptr_i itself.
        for (int unsigned i = 1; i <= N_MASTER; i++) begin
            idx = PTR_W'((32'(ptr_i) + i) % N_MASTER);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/wishbone_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone B3 classic slave port among
// N_MASTER masters, with the bus locked for a whole master cycle and a
// watchdog that aborts a strobe left unanswered for TIMEOUT_CYC cycles.
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_m_cyc/stb/we        : per-master control, one bit per master
//   i_m_sel/addr/data     : per-master select/address/write data, packed by index
//   o_m_data              : slave read data, broadcast
//   o_m_ack, o_m_err      : per-master ack / error (granted master only)
//   o_s_*                 : slave-side request signals
//   i_s_data/ack/err      : slave-side response signals
//   o_grant               : registered one-hot grant
module wishbone_bus_arbiter
    import wishbone_arb_pkg::*;
#(
    parameter int unsigned N_MASTER    = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_MASTER-1:0]       i_m_cyc,
    input  logic [N_MASTER-1:0]       i_m_stb,
    input  logic [N_MASTER-1:0]       i_m_we,
    input  logic [SEL_W*N_MASTER-1:0] i_m_sel,
    input  logic [ADDR_W*N_MASTER-1:0] i_m_addr,
    input  logic [DATA_W*N_MASTER-1:0] i_m_data,
    output logic [DATA_W-1:0]         o_m_data,
    output logic [N_MASTER-1:0]       o_m_ack,
    output logic [N_MASTER-1:0]       o_m_err,
    output logic                      o_s_cyc,
    output logic                      o_s_stb,
    output logic                      o_s_we,
    output logic [SEL_W-1:0]          o_s_sel,
    output logic [ADDR_W-1:0]         o_s_addr,
    output logic [DATA_W-1:0]         o_s_data,
    input  logic [DATA_W-1:0]         i_s_data,
    input  logic                      i_s_ack,
    input  logic                      i_s_err,
    output logic [N_MASTER-1:0]       o_grant
);

    localparam int unsigned PTR_W    = $clog2(N_MASTER);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    arb_state_t          state_q, state_d;
    logic [N_MASTER-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [15:0]         tmo_q, tmo_d;

    logic [N_MASTER-1:0] pick_grant;
    logic                pick_valid;
    logic [PTR_W-1:0]    gidx;

    logic                g_cyc, g_stb, g_we;
    logic [SEL_W-1:0]    g_sel;
    logic [ADDR_W-1:0]   g_addr;
    logic [DATA_W-1:0]   g_data;

    wb_rr_picker #(
        .N_MASTER (N_MASTER),
        .PTR_W    (PTR_W)
    ) u_picker (
        .req_i   (i_m_cyc & i_m_stb),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .valid_o (pick_valid)
    );

    assign gidx    = PTR_W'(onehot2idx(8'(grant_q)));
    assign o_grant = grant_q;

    // Granted master's request fields.
    always_comb begin
        g_cyc  = i_m_cyc[gidx];
        g_stb  = i_m_stb[gidx];
        g_we   = i_m_we[gidx];
        g_sel  = i_m_sel[32'(gidx) * SEL_W +: SEL_W];
        g_addr = i_m_addr[32'(gidx) * ADDR_W +: ADDR_W];
        g_data = i_m_data[32'(gidx) * DATA_W +: DATA_W];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q   <= PTR_W'(N_MASTER - 1);
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        tmo_d    = '0;
        o_s_cyc  = 1'b0;
        o_s_stb  = 1'b0;
        o_s_we   = 1'b0;
        o_s_sel  = '0;
        o_s_addr = '0;
        o_s_data = '0;
        o_m_data = '0;
        o_m_ack  = '0;
        o_m_err  = '0;

        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_grant;
                    state_d = S_BUSY;
                end
            end

            S_BUSY: begin
                o_s_cyc  = g_cyc;
                o_s_stb  = g_cyc & g_stb;
                o_s_we   = g_we;
                o_s_sel  = g_sel;
                o_s_addr = g_addr;
                o_s_data = g_data;
                o_m_data = i_s_data;
                o_m_ack  = grant_q & i_m_stb & {N_MASTER{i_s_ack}};
                o_m_err  = grant_q & i_m_stb & {N_MASTER{i_s_err}};

                if (!g_cyc) begin
                    ptr_d   = gidx;
                    grant_d = '0;
                    state_d = S_IDLE;
                end else if (o_s_stb && !i_s_ack && !i_s_err) begin
                    // Any ack/err or stb-low cycle leaves tmo_d at its
                    // cleared default, so a same-cycle ack beats expiry.
                    if (tmo_q == TMO_LAST) begin
                        o_m_err = grant_q;
                        state_d = S_ABORT;
                    end else begin
                        tmo_d = tmo_q + 16'd1;
                    end
                end
            end

            S_ABORT: begin
                ptr_d   = gidx;
                grant_d = '0;
                state_d = S_IDLE;
            end

            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wishbone_bus_arbiter.sv
module tb_wishbone_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_cyc, m_stb, m_we;
    logic [7:0]  m_sel;
    logic [63:0] m_addr, m_data;
    logic [31:0] s_data;
    logic        s_ack, s_err;

    logic [31:0] o_m_data, o_s_addr, o_s_data;
    logic [1:0]  o_m_ack, o_m_err, o_grant;
    logic        o_s_cyc, o_s_stb, o_s_we;
    logic [3:0]  o_s_sel;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wishbone_bus_arbiter #(
        .N_MASTER    (2),
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_m_cyc  (m_cyc),
        .i_m_stb  (m_stb),
        .i_m_we   (m_we),
        .i_m_sel  (m_sel),
        .i_m_addr (m_addr),
        .i_m_data (m_data),
        .o_m_data (o_m_data),
        .o_m_ack  (o_m_ack),
        .o_m_err  (o_m_err),
        .o_s_cyc  (o_s_cyc),
        .o_s_stb  (o_s_stb),
        .o_s_we   (o_s_we),
        .o_s_sel  (o_s_sel),
        .o_s_addr (o_s_addr),
        .o_s_data (o_s_data),
        .i_s_data (s_data),
        .i_s_ack  (s_ack),
        .i_s_err  (s_err),
        .o_grant  (o_grant)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive point: 1 time unit after the rising edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] addr, input logic [31:0] data);
        m_cyc[k]          = cyc;
        m_stb[k]          = stb;
        m_we[k]           = we;
        m_sel[4*k +: 4]   = 4'hF;
        m_addr[32*k +: 32] = addr;
        m_data[32*k +: 32] = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_addr = '0; m_data = '0;
        s_data = '0; s_ack = 1'b0; s_err = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_s_cyc", o_s_cyc, 0);
        check("rst_s_stb", o_s_stb, 0);
        check("rst_grant", o_grant, 2'b00);
        check("rst_ack", o_m_ack, 2'b00);
        check("rst_mdata", o_m_data, 0);
        rst = 1'b0;

        // Single read by master 0, slave acks in the third strobe cycle
        next();
        set_m(0, 1, 1, 0, 32'h0000_0100, 0);
        #1 check("t1_stb_not_yet", o_s_stb, 0);
        next(); #1;
        check("t1_stb_up", o_s_stb, 1);
        check("t1_addr", o_s_addr, 32'h0000_0100);
        check("t1_we", o_s_we, 0);
        check("t1_grant", o_grant, 2'b01);
        next(); #1;
        check("t1_no_ack_yet", o_m_ack, 2'b00);
        next();
        s_ack = 1'b1; s_data = 32'hDEADBEEF;
        #1;
        check("t1_ack", o_m_ack, 2'b01);
        check("t1_rdata", o_m_data, 32'hDEADBEEF);
        next();
        s_ack = 1'b0; s_data = '0;
        set_m(0, 0, 0, 0, 0, 0);
        #1;
        check("t1_ack_gone", o_m_ack, 2'b00);
        check("t1_cyc_low", o_s_cyc, 0);
        next(); #1;
        check("t1_idle_grant", o_grant, 2'b00);
        check("t1_idle_mdata", o_m_data, 0);

        // Simultaneous requests from a fresh reset
        rst = 1'b1;
        #1 rst = 1'b0;
        set_m(0, 1, 1, 0, 32'h200, 0);
        set_m(1, 1, 1, 0, 32'h300, 0);
        next();
        s_ack = 1'b1;
        #1;
        check("t2_first_m0", o_grant, 2'b01);
        check("t2_addr0", o_s_addr, 32'h200);
        check("t2_ack_m0_only", o_m_ack, 2'b01);
        next();
        s_ack = 1'b0;
        set_m(0, 0, 0, 0, 0, 0);
        #1;
        check("t2_drop_cyc", o_s_cyc, 0);
        next(); #1;
        check("t2_idle_gap", o_s_cyc, 0);
        check("t2_idle_grant", o_grant, 2'b00);
        next();
        set_m(0, 1, 1, 0, 32'h210, 0);
        s_ack = 1'b1;
        #1;
        check("t2_second_m1", o_grant, 2'b10);
        check("t2_addr1", o_s_addr, 32'h300);
        check("t2_ack_m1_only", o_m_ack, 2'b10);
        next();
        s_ack = 1'b0;
        set_m(1, 0, 0, 0, 0, 0);
        next();
        next(); #1;
        check("t2_third_m0", o_grant, 2'b01);
        check("t2_addr0b", o_s_addr, 32'h210);
        s_ack = 1'b1;
        next();
        s_ack = 1'b0;
        set_m(0, 0, 0, 0, 0, 0);
        next();

        // Lock: master 1 holds cyc over three writes while master 0 waits
        set_m(1, 1, 1, 1, 32'h400, 32'h11);
        set_m(0, 1, 1, 0, 32'h500, 0);
        next();
        s_ack = 1'b1;
        #1;
        check("t3_grant_m1", o_grant, 2'b10);
        check("t3_w1_data", o_s_data, 32'h11);
        check("t3_w1_we", o_s_we, 1);
        check("t3_w1_sel", o_s_sel, 4'hF);
        check("t3_w1_ack", o_m_ack, 2'b10);
        next();
        s_ack = 1'b0;
        m_stb[1] = 1'b0;
        #1;
        check("t3_gap_stb", o_s_stb, 0);
        check("t3_gap_lock", o_grant, 2'b10);
        next();
        set_m(1, 1, 1, 1, 32'h404, 32'h22);
        s_ack = 1'b1;
        #1;
        check("t3_w2_data", o_s_data, 32'h22);
        check("t3_w2_addr", o_s_addr, 32'h404);
        next();
        set_m(1, 1, 1, 1, 32'h408, 32'h33);
        #1;
        check("t3_w3_data", o_s_data, 32'h33);
        check("t3_w3_lock", o_grant, 2'b10);
        next();
        s_ack = 1'b0;
        set_m(1, 0, 0, 0, 0, 0);
        #1;
        check("t3_release_cyc", o_s_cyc, 0);
        next(); #1;
        check("t3_idle_grant", o_grant, 2'b00);
        next(); #1;
        check("t3_m0_after", o_grant, 2'b01);
        check("t3_m0_addr", o_s_addr, 32'h500);
        s_ack = 1'b1;
        next();
        s_ack = 1'b0;
        set_m(0, 0, 0, 0, 0, 0);
        next();

        // Timeout: slave never answers; err lands in the 8th strobe cycle
        set_m(0, 1, 1, 0, 32'h600, 0);
        next(); #1;
        check("t4_stb_up", o_s_stb, 1);
        for (int i = 1; i < 7; i++) next();
        #1;
        check("t4_no_err_early", o_m_err, 2'b00);
        next(); #1;
        check("t4_err", o_m_err, 2'b01);
        check("t4_err_ack", o_m_ack, 2'b00);
        next();
        s_ack = 1'b1;
        set_m(0, 0, 0, 0, 0, 0);
        #1;
        check("t4_abort_cyc", o_s_cyc, 0);
        check("t4_abort_err_gone", o_m_err, 2'b00);
        check("t4_late_ack_abort", o_m_ack, 2'b00);
        next(); #1;
        check("t4_late_ack_idle", o_m_ack, 2'b00);
        s_ack = 1'b0;
        next();

        // Expiry tie: ack in the cycle the counter would expire
        set_m(0, 1, 1, 0, 32'h700, 0);
        next();
        for (int i = 1; i < 8; i++) next();
        s_ack = 1'b1; s_data = 32'hCAFEF00D;
        #1;
        check("t5_tie_ack", o_m_ack, 2'b01);
        check("t5_tie_no_err", o_m_err, 2'b00);
        check("t5_tie_data", o_m_data, 32'hCAFEF00D);
        next();
        s_ack = 1'b0; s_data = '0;
        #1;
        check("t5_still_busy", o_s_cyc, 1);
        check("t5_no_err_after", o_m_err, 2'b00);
        next();
        set_m(0, 0, 0, 0, 0, 0);
        next();
        next();

        // Reset in the middle of a transfer
        set_m(0, 1, 1, 0, 32'h800, 0);
        set_m(1, 1, 1, 0, 32'h900, 0);
        next(); #1;
        check("t6_grant_m1", o_grant, 2'b10);
        check("t6_cyc_up", o_s_cyc, 1);
        s_ack = 1'b1;
        rst = 1'b1;
        #1;
        check("t6_rst_cyc", o_s_cyc, 0);
        check("t6_rst_stb", o_s_stb, 0);
        check("t6_rst_grant", o_grant, 2'b00);
        check("t6_rst_ack", o_m_ack, 2'b00);
        check("t6_rst_addr", o_s_addr, 0);
        rst = 1'b0;
        s_ack = 1'b0;
        next(); #1;
        check("t6_m0_priority", o_grant, 2'b01);
        check("t6_m0_addr", o_s_addr, 32'h800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
